// File: rtl/ibex_fp_wb_arbiter.sv
// FP writeback arbiter: merges FLW load data and buffered FPU results into
// the single FP register file write port, and tracks in-flight destinations
// in a pending scoreboard for decode RAW-hazard stalls.
module ibex_fp_wb_arbiter #(
    parameter int DataWidth  = 32,
    parameter int FifoDepth  = 2,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          fpu_valid_i,
    output logic                          fpu_ready_o,
    input  logic [ADDR_WIDTH-1:0]         fpu_rd_i,
    input  logic [DataWidth-1:0]          fpu_result_i,
    input  logic                          lsu_valid_i,
    input  logic [ADDR_WIDTH-1:0]         lsu_rd_i,
    input  logic [DataWidth-1:0]          lsu_rdata_i,
    input  logic                          issue_i,
    input  logic [ADDR_WIDTH-1:0]         issue_rd_i,
    input  logic [ADDR_WIDTH-1:0]         raddr_a_i,
    input  logic [ADDR_WIDTH-1:0]         raddr_b_i,
    input  logic [ADDR_WIDTH-1:0]         raddr_c_i,
    input  logic [2:0]                    rs_used_i,
    output logic                          hazard_o,
    output logic [ADDR_WIDTH-1:0]         waddr_a_o,
    output logic [DataWidth-1:0]          wdata_a_o,
    output logic                          we_a_o,
    output logic [2**ADDR_WIDTH-1:0]      pending_o,
    output logic [$clog2(FifoDepth):0]    fifo_cnt_o
);

    localparam int NumRegs = 2 ** ADDR_WIDTH;
    localparam int PtrW    = $clog2(FifoDepth);
    localparam int CntW    = PtrW + 1;
    localparam int EntryW  = ADDR_WIDTH + DataWidth;
    localparam logic [CntW-1:0] DepthC = CntW'(FifoDepth);

    // FPU result buffer: each entry holds {rd, result}
    logic [EntryW-1:0]     fifo_mem_r [FifoDepth];
    logic [PtrW-1:0]       wr_ptr_r;
    logic [PtrW-1:0]       rd_ptr_r;
    logic [CntW-1:0]       fifo_cnt_r;
    logic [EntryW-1:0]     fifo_head_s;

    logic                  fpu_hs_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  wr_sel_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [DataWidth-1:0]  wr_data_s;

    logic                  we_a_r;
    logic [ADDR_WIDTH-1:0] waddr_a_r;
    logic [DataWidth-1:0]  wdata_a_r;

    logic [NumRegs-1:0]    pending_r;
    logic [NumRegs-1:0]    pending_d_s;

    assign fifo_head_s = fifo_mem_r[rd_ptr_r];
    // Ready is withheld during reset so no result is lost while state clears
    assign fpu_ready_o = ~rst_i & (fifo_cnt_r < DepthC);
    assign fpu_hs_s    = fpu_valid_i & fpu_ready_o;

    // Source select: LSU beats buffered results, which beat a direct FPU bypass
    always_comb begin
        push_s    = 1'b0;
        pop_s     = 1'b0;
        wr_sel_s  = 1'b0;
        wr_addr_s = {ADDR_WIDTH{1'b0}};
        wr_data_s = {DataWidth{1'b0}};
        if (lsu_valid_i) begin
            wr_sel_s  = 1'b1;
            wr_addr_s = lsu_rd_i;
            wr_data_s = lsu_rdata_i;
            push_s    = fpu_hs_s;
        end else if (fifo_cnt_r != {CntW{1'b0}}) begin
            wr_sel_s  = 1'b1;
            wr_addr_s = fifo_head_s[EntryW-1:DataWidth];
            wr_data_s = fifo_head_s[DataWidth-1:0];
            pop_s     = 1'b1;
            push_s    = fpu_hs_s;
        end else if (fpu_hs_s) begin
            wr_sel_s  = 1'b1;
            wr_addr_s = fpu_rd_i;
            wr_data_s = fpu_result_i;
        end else begin
            wr_sel_s  = 1'b0;
        end
    end

    // Buffer storage: data payload needs no reset, occupancy is tracked separately
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {fpu_rd_i, fpu_result_i};
        end
    end

    // Buffer pointers and occupancy; power-of-two depth makes pointers wrap naturally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r   <= {PtrW{1'b0}};
            rd_ptr_r   <= {PtrW{1'b0}};
            fifo_cnt_r <= {CntW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PtrW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PtrW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CntW'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CntW'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Registered write port; register 0 is never written
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_a_r    <= 1'b0;
            waddr_a_r <= {ADDR_WIDTH{1'b0}};
            wdata_a_r <= {DataWidth{1'b0}};
        end else begin
            we_a_r    <= wr_sel_s & (wr_addr_s != {ADDR_WIDTH{1'b0}});
            waddr_a_r <= wr_addr_s;
            wdata_a_r <= wr_data_s;
        end
    end

    // Scoreboard next state: clear on the register file write, then set on issue so set wins
    always_comb begin
        pending_d_s = pending_r;
        if (we_a_r) begin
            pending_d_s[waddr_a_r] = 1'b0;
        end else begin
            pending_d_s = pending_d_s;
        end
        if (issue_i && (issue_rd_i != {ADDR_WIDTH{1'b0}})) begin
            pending_d_s[issue_rd_i] = 1'b1;
        end else begin
            pending_d_s = pending_d_s;
        end
        pending_d_s[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_r <= {NumRegs{1'b0}};
        end else begin
            pending_r <= pending_d_s;
        end
    end

    assign hazard_o = (rs_used_i[0] & pending_r[raddr_a_i])
                    | (rs_used_i[1] & pending_r[raddr_b_i])
                    | (rs_used_i[2] & pending_r[raddr_c_i]);

    assign we_a_o     = we_a_r;
    assign waddr_a_o  = waddr_a_r;
    assign wdata_a_o  = wdata_a_r;
    assign pending_o  = pending_r;
    assign fifo_cnt_o = fifo_cnt_r;

endmodule

// File: tb/tb_ibex_fp_wb_arbiter.sv
// Directed self-checking bench for ibex_fp_wb_arbiter.
module tb_ibex_fp_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fpu_valid_i;
    logic        fpu_ready_o;
    logic [4:0]  fpu_rd_i;
    logic [31:0] fpu_result_i;
    logic        lsu_valid_i;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_rdata_i;
    logic        issue_i;
    logic [4:0]  issue_rd_i;
    logic [4:0]  raddr_a_i;
    logic [4:0]  raddr_b_i;
    logic [4:0]  raddr_c_i;
    logic [2:0]  rs_used_i;
    logic        hazard_o;
    logic [4:0]  waddr_a_o;
    logic [31:0] wdata_a_o;
    logic        we_a_o;
    logic [31:0] pending_o;
    logic [1:0]  fifo_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    ibex_fp_wb_arbiter #(.DataWidth(32), .FifoDepth(2), .ADDR_WIDTH(5)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .fpu_valid_i  (fpu_valid_i),
        .fpu_ready_o  (fpu_ready_o),
        .fpu_rd_i     (fpu_rd_i),
        .fpu_result_i (fpu_result_i),
        .lsu_valid_i  (lsu_valid_i),
        .lsu_rd_i     (lsu_rd_i),
        .lsu_rdata_i  (lsu_rdata_i),
        .issue_i      (issue_i),
        .issue_rd_i   (issue_rd_i),
        .raddr_a_i    (raddr_a_i),
        .raddr_b_i    (raddr_b_i),
        .raddr_c_i    (raddr_c_i),
        .rs_used_i    (rs_used_i),
        .hazard_o     (hazard_o),
        .waddr_a_o    (waddr_a_o),
        .wdata_a_o    (wdata_a_o),
        .we_a_o       (we_a_o),
        .pending_o    (pending_o),
        .fifo_cnt_o   (fifo_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; fpu_valid_i = 1'b0; fpu_rd_i = 5'd0; fpu_result_i = 32'd0;
        lsu_valid_i = 1'b0; lsu_rd_i = 5'd0; lsu_rdata_i = 32'd0;
        issue_i = 1'b0; issue_rd_i = 5'd0;
        raddr_a_i = 5'd0; raddr_b_i = 5'd0; raddr_c_i = 5'd0; rs_used_i = 3'b000;
        tick();
        tick();
        n_checks++; if (we_a_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", we_a_o); end
        n_checks++; if (waddr_a_o !== 5'd0) begin n_fail++; $display("FAIL reset_waddr got %0d want 0", waddr_a_o); end
        n_checks++; if (wdata_a_o !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", wdata_a_o); end
        n_checks++; if (fifo_cnt_o !== 2'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", fifo_cnt_o); end
        n_checks++; if (pending_o !== 32'd0) begin n_fail++; $display("FAIL reset_pending got %h want 0", pending_o); end
        n_checks++; if (fpu_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_reset got %b want 0", fpu_ready_o); end
        rst_i = 1'b0;
        #1;
        n_checks++; if (fpu_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got %b want 1", fpu_ready_o); end
    endtask

    task automatic test_direct_fpu();
        fpu_valid_i = 1'b1; fpu_rd_i = 5'd5; fpu_result_i = 32'h4000_0000;
        #1;
        n_checks++; if (fpu_ready_o !== 1'b1) begin n_fail++; $display("FAIL direct_ready got %b want 1", fpu_ready_o); end
        tick();
        fpu_valid_i = 1'b0;
        n_checks++; if ({we_a_o, waddr_a_o, wdata_a_o} !== {1'b1, 5'd5, 32'h4000_0000}) begin
            n_fail++; $display("FAIL direct_write got we=%b a=%0d d=%h want we=1 a=5 d=40000000", we_a_o, waddr_a_o, wdata_a_o);
        end
        n_checks++; if (fifo_cnt_o !== 2'd0) begin n_fail++; $display("FAIL direct_cnt got %0d want 0", fifo_cnt_o); end
        tick();
        n_checks++; if (we_a_o !== 1'b0) begin n_fail++; $display("FAIL direct_one_cycle got %b want 0", we_a_o); end
    endtask

    task automatic test_lsu_fpu_collision();
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd3; lsu_rdata_i = 32'h3ecc_cccc;
        fpu_valid_i = 1'b1; fpu_rd_i = 5'd4; fpu_result_i = 32'h3f80_0000;
        tick();
        lsu_valid_i = 1'b0; fpu_valid_i = 1'b0;
        n_checks++; if ({we_a_o, waddr_a_o, wdata_a_o} !== {1'b1, 5'd3, 32'h3ecc_cccc}) begin
            n_fail++; $display("FAIL collide_lsu got we=%b a=%0d d=%h want we=1 a=3 d=3ecccccc", we_a_o, waddr_a_o, wdata_a_o);
        end
        n_checks++; if (fifo_cnt_o !== 2'd1) begin n_fail++; $display("FAIL collide_cnt1 got %0d want 1", fifo_cnt_o); end
        tick();
        n_checks++; if ({we_a_o, waddr_a_o, wdata_a_o} !== {1'b1, 5'd4, 32'h3f80_0000}) begin
            n_fail++; $display("FAIL collide_fpu got we=%b a=%0d d=%h want we=1 a=4 d=3f800000", we_a_o, waddr_a_o, wdata_a_o);
        end
        n_checks++; if (fifo_cnt_o !== 2'd0) begin n_fail++; $display("FAIL collide_cnt0 got %0d want 0", fifo_cnt_o); end
        tick();
        n_checks++; if (we_a_o !== 1'b0) begin n_fail++; $display("FAIL collide_idle got %b want 0", we_a_o); end
    endtask

    task automatic test_fifo_full();
        // Expected per cycle c: ready before edge, write after edge, occupancy after edge
        logic        exp_ready [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        exp_we    [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [4:0]  exp_addr  [8] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd1, 5'd2, 5'd3, 5'd0};
        logic [31:0] exp_data  [8] = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003,
                                       32'h2000_0001, 32'h2000_0002, 32'h2000_0003, 32'h0};
        logic [1:0]  exp_cnt   [8] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};
        int idx = 0;
        logic hs;
        for (int c = 0; c < 8; c++) begin
            lsu_valid_i  = (c < 4);
            lsu_rd_i     = 5'(10 + c);
            lsu_rdata_i  = 32'h1000_0000 + 32'(c);
            fpu_valid_i  = (idx < 3);
            fpu_rd_i     = 5'(idx + 1);
            fpu_result_i = 32'h2000_0000 + 32'(idx + 1);
            #1;
            n_checks++; if (fpu_ready_o !== exp_ready[c]) begin
                n_fail++; $display("FAIL full_ready c=%0d got %b want %b", c, fpu_ready_o, exp_ready[c]);
            end
            hs = fpu_valid_i & fpu_ready_o;
            tick();
            if (hs) idx++;
            n_checks++; if (we_a_o !== exp_we[c] || (exp_we[c] && (waddr_a_o !== exp_addr[c] || wdata_a_o !== exp_data[c]))) begin
                n_fail++; $display("FAIL full_write c=%0d got we=%b a=%0d d=%h want we=%b a=%0d d=%h",
                                   c, we_a_o, waddr_a_o, wdata_a_o, exp_we[c], exp_addr[c], exp_data[c]);
            end
            n_checks++; if (fifo_cnt_o !== exp_cnt[c]) begin
                n_fail++; $display("FAIL full_cnt c=%0d got %0d want %0d", c, fifo_cnt_o, exp_cnt[c]);
            end
        end
        lsu_valid_i = 1'b0; fpu_valid_i = 1'b0;
    endtask

    task automatic test_scoreboard();
        issue_i = 1'b1; issue_rd_i = 5'd7;
        tick();
        issue_i = 1'b0;
        n_checks++; if (pending_o !== 32'h0000_0080) begin n_fail++; $display("FAIL sb_set got %h want 00000080", pending_o); end
        raddr_a_i = 5'd2; raddr_b_i = 5'd7; raddr_c_i = 5'd9; rs_used_i = 3'b010;
        #1;
        n_checks++; if (hazard_o !== 1'b1) begin n_fail++; $display("FAIL sb_hazard_b got %b want 1", hazard_o); end
        rs_used_i = 3'b101;
        #1;
        n_checks++; if (hazard_o !== 1'b0) begin n_fail++; $display("FAIL sb_hazard_unused got %b want 0", hazard_o); end
        rs_used_i = 3'b010;
        fpu_valid_i = 1'b1; fpu_rd_i = 5'd7; fpu_result_i = 32'h4040_0000;
        tick();
        fpu_valid_i = 1'b0;
        n_checks++; if (we_a_o !== 1'b1 || waddr_a_o !== 5'd7) begin
            n_fail++; $display("FAIL sb_write7 got we=%b a=%0d want we=1 a=7", we_a_o, waddr_a_o);
        end
        n_checks++; if (hazard_o !== 1'b1) begin n_fail++; $display("FAIL sb_hazard_during_we got %b want 1", hazard_o); end
        // Reissue r7 on the same edge that clears it
        issue_i = 1'b1; issue_rd_i = 5'd7;
        tick();
        issue_i = 1'b0;
        n_checks++; if (pending_o[7] !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins got %b want 1", pending_o[7]); end
        n_checks++; if (hazard_o !== 1'b1) begin n_fail++; $display("FAIL sb_hazard_reissued got %b want 1", hazard_o); end
        fpu_valid_i = 1'b1; fpu_rd_i = 5'd7; fpu_result_i = 32'h4080_0000;
        tick();
        fpu_valid_i = 1'b0;
        n_checks++; if (hazard_o !== 1'b1) begin n_fail++; $display("FAIL sb_hazard_before_clear got %b want 1", hazard_o); end
        tick();
        n_checks++; if (hazard_o !== 1'b0) begin n_fail++; $display("FAIL sb_hazard_cleared got %b want 0", hazard_o); end
        n_checks++; if (pending_o !== 32'd0) begin n_fail++; $display("FAIL sb_cleared got %h want 0", pending_o); end
        rs_used_i = 3'b000;
    endtask

    task automatic test_rd_zero();
        fpu_valid_i = 1'b1; fpu_rd_i = 5'd0; fpu_result_i = 32'hdead_beef;
        #1;
        n_checks++; if (fpu_ready_o !== 1'b1) begin n_fail++; $display("FAIL rd0_ready got %b want 1", fpu_ready_o); end
        tick();
        fpu_valid_i = 1'b0;
        n_checks++; if (we_a_o !== 1'b0) begin n_fail++; $display("FAIL rd0_we got %b want 0", we_a_o); end
        n_checks++; if (fifo_cnt_o !== 2'd0) begin n_fail++; $display("FAIL rd0_cnt got %0d want 0", fifo_cnt_o); end
        issue_i = 1'b1; issue_rd_i = 5'd0;
        tick();
        issue_i = 1'b0;
        n_checks++; if (pending_o !== 32'd0) begin n_fail++; $display("FAIL rd0_pending got %h want 0", pending_o); end
    endtask

    task automatic test_reset_mid();
        issue_i = 1'b1; issue_rd_i = 5'd8;
        tick();
        issue_rd_i = 5'd9;
        tick();
        issue_i = 1'b0;
        n_checks++; if (pending_o !== 32'h0000_0300) begin n_fail++; $display("FAIL mid_pending_set got %h want 00000300", pending_o); end
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd12; lsu_rdata_i = 32'h1234_5678;
        fpu_valid_i = 1'b1; fpu_rd_i = 5'd8; fpu_result_i = 32'h5555_0008;
        tick();
        fpu_rd_i = 5'd9; fpu_result_i = 32'h5555_0009;
        tick();
        lsu_valid_i = 1'b0; fpu_valid_i = 1'b0;
        n_checks++; if (fifo_cnt_o !== 2'd2) begin n_fail++; $display("FAIL mid_cnt_full got %0d want 2", fifo_cnt_o); end
        rst_i = 1'b1;
        tick();
        n_checks++; if (fifo_cnt_o !== 2'd0) begin n_fail++; $display("FAIL mid_cnt got %0d want 0", fifo_cnt_o); end
        n_checks++; if (pending_o !== 32'd0) begin n_fail++; $display("FAIL mid_pending got %h want 0", pending_o); end
        n_checks++; if (we_a_o !== 1'b0) begin n_fail++; $display("FAIL mid_we got %b want 0", we_a_o); end
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (we_a_o !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale_write i=%0d got we=%b a=%0d", i, we_a_o, waddr_a_o); end
        end
    endtask

    initial begin
        test_reset();
        test_direct_fpu();
        test_lsu_fpu_collision();
        test_fifo_full();
        test_scoreboard();
        test_rd_zero();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_fp_wb_arbiter.md
Name: ibex_fp_wb_arbiter

Overview:
- Writeback stage directly upstream of the FP register file's single write port (waddr/wdata/we).
- Merges FPU results (valid/ready handshake) and FP load (FLW) data (no backpressure) into one registered write per cycle.
- Keeps a per-register pending scoreboard so decode can stall on RAW hazards against in-flight FP destinations.

Parameters:
DataWidth, 32, width of FP data and write port
FifoDepth, 2, FPU result buffer entries (power of two, >=2)
ADDR_WIDTH, 5, FP register address width; 2**ADDR_WIDTH registers

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
fpu_valid_i  in  1  FPU result available
fpu_ready_o  out  1  arbiter accepts FPU result this cycle
fpu_rd_i  in  ADDR_WIDTH  FPU destination register
fpu_result_i  in  DataWidth  FPU result
lsu_valid_i  in  1  FLW data valid; must be consumed this cycle
lsu_rd_i  in  ADDR_WIDTH  load destination register
lsu_rdata_i  in  DataWidth  load data
issue_i  in  1  FP-writing instruction issued; marks issue_rd_i pending
issue_rd_i  in  ADDR_WIDTH  destination of issued instruction
raddr_a_i/raddr_b_i/raddr_c_i  in  ADDR_WIDTH each  decode source operands
rs_used_i  in  3  {c,b,a} operand-used flags
hazard_o  out  1  a used operand is pending
waddr_a_o  out  ADDR_WIDTH  register file write address
wdata_a_o  out  DataWidth  register file write data
we_a_o  out  1  register file write enable
pending_o  out  2**ADDR_WIDTH  scoreboard; bit 0 always 0
fifo_cnt_o  out  $clog2(FifoDepth)+1  FPU buffer occupancy

Behaviour:
- Reset (rst_i high at clock edge): we_a_o=0, waddr_a_o=0, wdata_a_o=0, FIFO empty, fifo_cnt_o=0, pending_o=0. fpu_ready_o=0 while rst_i high, else fpu_ready_o = (fifo_cnt_o < FifoDepth). Reset mid-operation discards buffered results and pending bits.
- Write outputs are registered: source selected in cycle N gives we_a_o/waddr_a_o/wdata_a_o in cycle N+1, held one cycle only.
- Source priority per cycle: LSU > FIFO head > direct FPU.
  - LSU valid: LSU written. An accepted FPU result is pushed to FIFO. FIFO does not pop.
  - No LSU, FIFO non-empty: head popped and written. An accepted FPU result is pushed to the tail in the same cycle (push+pop, count unchanged).
  - No LSU, FIFO empty, FPU handshake: FPU result written directly, bypassing the FIFO.
  - Result: FPU results are written in acceptance order.
- FIFO full and FPU valid: fpu_ready_o=0; the result is held upstream with no loss. If LSU is also valid, the LSU write proceeds.
- Continuous lsu_valid_i starves FIFO drain; this is accepted behaviour, and load streams are bounded by the LSU.
- Destination 0: the result is consumed (and popped if buffered), but the registered we_a_o=0. issue_i with rd 0 sets nothing.
- Scoreboard:
  - On each edge with issue_i=1, set pending[issue_rd_i].
  - On each edge with we_a_o=1, clear pending[waddr_a_o], so the clear coincides with the register file update.
  - Set and clear of the same index on the same edge: set wins.
- hazard_o is combinational: OR over i in {a,b,c} of rs_used_i[i] & pending[raddr_i]. No forwarding.
- Pointers wrap modulo FifoDepth. fifo_cnt_o is exact; it never exceeds FifoDepth or underflows.

Test Plan:
- Reset with rst_i=1 for 2 cycles, then FPU rd=5, data 0x40000000 on an idle bus -> we_a_o=1, waddr=5, wdata=0x40000000 exactly one cycle after the handshake; fifo_cnt_o stays 0.
- Same cycle: LSU rd=3 data 0x3ecccccc and FPU rd=4 data 0x3f800000 -> cycle+1 writes r3, cycle+2 writes r4; fifo_cnt_o goes 1 then 0.
- LSU valid 4 consecutive cycles while FPU presents rd=1,2,3 -> fpu_ready_o drops after 2 accepts; after LSU stops, writes r1,r2,r3 in order; no drop or duplicate.
- issue rd=7, then decode raddr_b=7 with rs_used=3'b010 -> hazard_o=1 until the edge after we_a_o for r7, then 0. Issue rd=7 on that same clear edge -> pending[7] stays 1.
- FPU result rd=0, data 0xdeadbeef -> handshake completes, we_a_o stays 0, pending_o unchanged.
- Assert rst_i with FIFO holding 2 entries and pending bits set -> next cycle fifo_cnt_o=0, pending_o=0, we_a_o=0; buffered results are never written.
